// File: rtl/msk_unmask_serializer_pkg.sv
// msk_unmask_serializer_pkg: block/word geometry and FSM encoding shared by the serializer files.
package msk_unmask_serializer_pkg;
  localparam int BLOCK_W = 128;
  localparam int WORD_W = 32;
  localparam int N_WORDS = 4;
  localparam int CNT_W = $clog2(N_WORDS);
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
endpackage

// File: rtl/msk_unmask_serializer_if.sv
// msk_unmask_serializer_if: share-block input handshake and 32-bit word output handshake.
interface msk_unmask_serializer_if
  import msk_unmask_serializer_pkg::*;
#(
  parameter int d = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BLOCK_W*d-1:0]  in_shares_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_W-1:0]     out_data;
  logic                  out_last;
  modport master (output in_valid, in_shares_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_shares_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/endian_reverse.sv
// endian_reverse: reverses the order of WIDTH-bit lanes across a BSIZE-bit word.
module endian_reverse #(
  parameter int BSIZE = 128,
  parameter int WIDTH = 8
) (
  input  logic [BSIZE-1:0] data_i,
  output logic [BSIZE-1:0] data_o
);
  for (genvar g = 0; g < BSIZE / WIDTH; g++) begin : g_lane
    assign data_o[WIDTH*g +: WIDTH] = data_i[BSIZE-WIDTH*(g+1) +: WIDTH];
  end
endmodule

// File: rtl/msk_share_xor_reduce.sv
// msk_share_xor_reduce: combinational XOR of d shares laid out share-major on one bus.
module msk_share_xor_reduce #(
  parameter int d = 2,
  parameter int count = 128
) (
  input  logic [count*d-1:0] shares_i,
  output logic [count-1:0]   data_o
);
  always_comb begin
    data_o = '0;
    for (int j = 0; j < d; j++) data_o = data_o ^ shares_i[count*j +: count];
  end
endmodule

// File: rtl/msk_unmask_serializer.sv
// msk_unmask_serializer: recombines one d-share 128-bit block and streams it out as four 32-bit words.
module msk_unmask_serializer
  import msk_unmask_serializer_pkg::*;
#(
  parameter int d = 2,
  parameter bit BYTE_REVERSE = 1'b0
) (
  input logic clk,
  input logic rst,
  msk_unmask_serializer_if.slave bus
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] data_q, data_d, plain, plain_rev;
  logic               in_fire, out_fire;
  msk_share_xor_reduce #(.d(d), .count(BLOCK_W)) u_xor (
    .shares_i(bus.in_shares_data),
    .data_o  (plain)
  );
  endian_reverse #(.BSIZE(BLOCK_W), .WIDTH(8)) u_rev (
    .data_i(plain),
    .data_o(plain_rev)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  // The final beat clears the block so no unmasked residue survives past the last word.
  always_comb begin
    in_fire  = bus.in_valid & bus.in_ready;
    out_fire = bus.out_valid & bus.out_ready;
    state_d  = in_fire ? SEND : (out_fire & bus.out_last) ? IDLE : state_q;
    cnt_d    = in_fire ? '0 : out_fire ? cnt_q + CNT_W'(1) : cnt_q;
    data_d   = in_fire ? (BYTE_REVERSE ? plain_rev : plain) : (out_fire & bus.out_last) ? '0 : data_q;
  end
  always_comb begin
    bus.out_valid = state_q == SEND;
    bus.out_last  = bus.out_valid & (cnt_q == CNT_W'(N_WORDS - 1));
    bus.in_ready  = !bus.out_valid | (bus.out_last & bus.out_ready);
    bus.out_data  = data_q[WORD_W*cnt_q +: WORD_W];
  end
endmodule

// File: tb/tb_msk_unmask_serializer.sv
// tb_msk_unmask_serializer: directed vectors for the unmasking word serializer.
module tb_msk_unmask_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] mask = '1;
  logic [127:0] blk1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  logic [127:0] blk2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  logic [127:0] tgt3 = 128'hffffffff_00000000_12345678_deadbeef;
  logic [127:0] s0 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  logic [127:0] s1 = 128'h13579bdf_2468ace0_fdb97531_eca86420;
  logic [255:0] exp_b = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
                         32'h5ac5b470, 32'h80b7cdd8, 32'h30047b6a, 32'hd8e0c469};
  logic [127:0] exp_c = {32'hffffffff, 32'h00000000, 32'h12345678, 32'hdeadbeef};
  logic [127:0] exp_bp = {32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
  logic [7:0] lfsr = 8'h01;
  int k;
  always #5 clk = ~clk;
  msk_unmask_serializer_if #(.d(2)) a_if ();
  msk_unmask_serializer_if #(.d(2)) b_if ();
  msk_unmask_serializer_if #(.d(3)) c_if ();
  msk_unmask_serializer #(.d(2), .BYTE_REVERSE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  msk_unmask_serializer #(.d(2), .BYTE_REVERSE(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
  msk_unmask_serializer #(.d(3), .BYTE_REVERSE(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(c_if));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_a(input logic [255:0] shares, input logic [127:0] exp, input string tag);
    a_if.in_shares_data = shares;
    a_if.in_valid = 1'b1;
    a_if.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(a_if.in_ready), 32'd1);
    tick();
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(a_if.out_valid), 32'd1);
      check($sformatf("%s_word%0d", tag, i), a_if.out_data, exp[32*i +: 32]);
      check($sformatf("%s_last%0d", tag, i), 32'(a_if.out_last), 32'(i == 3));
      tick();
    end
    check({tag, "_idle_valid"}, 32'(a_if.out_valid), 32'd0);
    check({tag, "_residue"}, a_if.out_data, 32'd0);
    check({tag, "_idle_ready"}, 32'(a_if.in_ready), 32'd1);
  endtask
  initial begin
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b0; a_if.in_shares_data = '0;
    b_if.in_valid = 1'b0; b_if.out_ready = 1'b0; b_if.in_shares_data = '0;
    c_if.in_valid = 1'b0; c_if.out_ready = 1'b0; c_if.in_shares_data = '0;
    #12;
    check("rst_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_last", 32'(a_if.out_last), 32'd0);
    check("rst_data", a_if.out_data, 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    check("rel_in_ready", 32'(a_if.in_ready), 32'd1);
    send_a({mask, blk1 ^ mask}, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, "basic");
    // back-pressure with LFSR-driven out_ready, seed 1
    a_if.in_shares_data = {mask, blk1 ^ mask};
    a_if.in_valid = 1'b1;
    a_if.out_ready = 1'b0;
    tick();
    a_if.in_valid = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 200 && k < 4; cyc++) begin
      a_if.out_ready = lfsr[0];
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      #1;
      check("bp_valid", 32'(a_if.out_valid), 32'd1);
      check($sformatf("bp_word%0d", k), a_if.out_data, exp_bp[32*k +: 32]);
      check("bp_last", 32'(a_if.out_last), 32'(k == 3));
      check("bp_in_ready", 32'(a_if.in_ready), 32'(k == 3 && a_if.out_ready));
      if (a_if.out_ready) k++;
      tick();
    end
    check("bp_handshakes", k, 32'd4);
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_extra", 32'(a_if.out_valid), 32'd0);
    end
    // reset in the middle of a block
    a_if.in_shares_data = {mask, blk1 ^ mask};
    a_if.in_valid = 1'b1;
    tick();
    a_if.in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_if.out_valid), 32'd0);
    check("mid_rst_data", a_if.out_data, 32'd0);
    check("mid_rst_last", 32'(a_if.out_last), 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    check("post_rst_ready", 32'(a_if.in_ready), 32'd1);
    check("post_rst_valid", 32'(a_if.out_valid), 32'd0);
    send_a({128'h0, blk2}, 128'h00010203_04050607_08090a0b_0c0d0e0f, "after_rst");
    // byte-reversed, two blocks back to back
    b_if.out_ready = 1'b1;
    b_if.in_shares_data = {mask, blk1 ^ mask};
    b_if.in_valid = 1'b1;
    #1;
    check("b2b_in_ready", 32'(b_if.in_ready), 32'd1);
    tick();
    b_if.in_shares_data = {128'h0, blk2};
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_valid%0d", i), 32'(b_if.out_valid), 32'd1);
      check($sformatf("b2b_word%0d", i), b_if.out_data, exp_b[32*i +: 32]);
      check($sformatf("b2b_last%0d", i), 32'(b_if.out_last), 32'(i % 4 == 3));
      check($sformatf("b2b_in_ready%0d", i), 32'(b_if.in_ready), 32'(i % 4 == 3));
      tick();
      if (i == 3) b_if.in_valid = 1'b0;
    end
    check("b2b_idle", 32'(b_if.out_valid), 32'd0);
    check("b2b_residue", b_if.out_data, 32'd0);
    // three shares
    c_if.out_ready = 1'b1;
    c_if.in_shares_data = {tgt3 ^ s0 ^ s1, s1, s0};
    c_if.in_valid = 1'b1;
    tick();
    c_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d3_word%0d", i), c_if.out_data, exp_c[32*i +: 32]);
      check($sformatf("d3_last%0d", i), 32'(c_if.out_last), 32'(i == 3));
      tick();
    end
    check("d3_idle", 32'(c_if.out_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/msk_unmask_serializer.md
Name: msk_unmask_serializer

Overview:
- Output-side decoder for the masked AES cores: accepts one d-share 128-bit ciphertext over a valid/ready handshake, recombines the shares by XOR, and emits the unmasked block as four 32-bit words over a second valid/ready handshake.
- Sits between the out_shares_ciphertext/out_valid/out_ready interface of aes_enc128_32bits_hpc2 and a 32-bit host bus. It is the hardware counterpart of the bench's share-recombination path.

Parameters:
- d, 2, number of shares (>=2).
- BYTE_REVERSE, 0, 1 = reverse byte order of the recombined 128-bit block before splitting it into words.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  share block valid.
- in_ready  out  1  block accepted when in_valid & in_ready.
- in_shares_data  in  128*d  share-major layout: share j = in_shares_data[128*j +: 128].
- out_valid  out  1  word valid.
- out_ready  in  1  word consumed when out_valid & out_ready.
- out_data  out  32  current word.
- out_last  out  1  high with the 4th word of a block.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, beat counter=0, data register=0, out_valid=0, out_last=0, out_data=0. After release, in_ready=1.
- FSM has two states, IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: latch XOR of all d shares into a 128-bit register (byte-reversed if BYTE_REVERSE=1), clear cnt, go to SEND.
- SEND:
  - out_valid=1.
  - out_data = reg[32*cnt +: 32]; word0 is bits[31:0].
  - out_last = (cnt==3).
  - On out_ready: cnt+1.
  - On the handshake with cnt==3: clear the data register and go to IDLE, or take the next block directly (see below).
- Back-to-back: in_ready is also 1 in SEND when cnt==3 & out_ready. A simultaneous input handshake loads the new block, sets cnt=0 and stays in SEND. Throughput is one block per 4 cycles with no bubble.
- Latency: input handshake in cycle N gives word0 valid in cycle N+1. Outputs are registered; out_data is driven from the register via the counter mux only.
- Stall: while out_valid & !out_ready, out_data, out_last and cnt hold stable (AXI-stream rule). out_valid never drops before its handshake.
- in_valid with in_ready low: ignored; upstream holds per protocol.
- cnt is 2 bits and wraps 3→0 only on the final beat.
- Register cleared after the last beat, so no unmasked residue stays in the block.
- Reset mid-block: the block is discarded; no partial words are re-emitted.
- Unmasked data exists only from the recombination point onward. No share or intermediate value feeds any other logic.

Decomposition:
- Shared package/header: BLOCK_W=128, WORD_W=32, N_WORDS=4; state encoding localparams IDLE/SEND.
- Sub-module: msk_share_xor_reduce (combinational d-way XOR over share-major bus, parameter count=128). It can be reused by benches.
- The byte reversal reuses the existing endian_reverse (BSIZE=128, WIDTH=8) instance.

Test Plan:
- Basic, d=2, BYTE_REVERSE=0:
  - Stimulus: mask m=all-ones; share0 = 0x69c4e0d86a7b0430d8cdb78070b4c55a ^ m, share1 = m; out_ready=1.
  - Required: words 0x70b4c55a, 0xd8cdb780, 0x6a7b0430, 0x69c4e0d8; out_last on the 4th; word0 valid 1 cycle after accept.
- BYTE_REVERSE=1, same block:
  - Required: words 0xd8e0c469, 0x30047b6a, 0x80b7cdd8, 0x5ac5b470.
- Back-pressure:
  - Stimulus: out_ready toggles with pseudo-random pattern, seed 1.
  - Required: words stable while stalled, order unchanged, exactly 4 handshakes, in_ready low until the final beat.
- Back-to-back:
  - Stimulus: two blocks with in_valid held high; second block = 0x000102...0f unmasked (share1=0).
  - Required: 8 consecutive out handshakes with no idle cycle; second block word0 = 0x03020100.
- Reset mid-block:
  - Stimulus: assert rst low asynchronously after word1.
  - Required: out_valid=0 immediately; in_ready=1 after release; the next block's output is correct and old words never appear.
- d=3:
  - Stimulus: three random shares whose XOR = 0xffffffff_00000000_12345678_deadbeef.
  - Required: words 0xdeadbeef, 0x12345678, 0x00000000, 0xffffffff.
